// File: rtl/rgb_pkg.sv
// rgb_pkg: shared constants and types for the
// RGB565 test-pattern pixel source.
package rgb_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int BAR_W        = 60;

  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_GRID  = 3'd1;
  localparam logic [2:0] MODE_RAMP  = 3'd2;
  localparam logic [2:0] MODE_BOX   = 3'd3;
  localparam logic [2:0] MODE_CHECK = 3'd4;
  localparam logic [2:0] MODE_LAST  = 3'd4;

  localparam logic [15:0] C_WHITE = 16'hFFFF;
  localparam logic [15:0] C_BLACK = 16'h0000;
  localparam logic [15:0] C_RED   = 16'hF800;
  localparam logic [15:0] C_BLUE  = 16'h001F;

  // white, yellow, cyan, green,
  // magenta, red, blue, black
  localparam logic [0:7][15:0] BAR_LUT = {
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef struct packed {
    logic [10:0] pos;
    logic        left;
  } axis_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [5:0] ramp;
    logic [2:0] bar;
    logic       grid;
    logic       box;
    logic       chk;
  } s1_t;

  function automatic logic [2:0] bar_idx(
    input logic [10:0] x
  );
    logic [2:0] k;
    k = '0;
    for (int i = 1; i < 8; i++)
      if (x >= 11'(BAR_W * i)) k = 3'(i);
    return k;
  endfunction

  // bounce between 0 and lim in step units
  function automatic axis_t axis_next(
    input axis_t       a,
    input logic [10:0] lim,
    input logic [10:0] step
  );
    axis_t n;
    n = a;
    if (!a.left) begin
      if (a.pos >= lim - step) begin
        n.pos  = lim;
        n.left = 1'b1;
      end else begin
        n.pos = a.pos + step;
      end
    end else begin
      if (a.pos <= step) begin
        n.pos  = '0;
        n.left = 1'b0;
      end else begin
        n.pos = a.pos - step;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stability
// counter and one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 180000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic          deb;
  logic [CW-1:0] cnt;

  // bring the async key into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  // accept a new level only after it holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      deb   <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        deb   <= sync[1];
        press <= deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_pattern_gen.sv
// rgb_pattern_gen: two-stage RGB565 pattern
// source behind the LCD timing generator.
module rgb_pattern_gen
  import rgb_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter logic VS_POL     = 1'b0,
  parameter int   DEB_CYCLES = 180000,
  parameter int   BOX_SIZE   = 32,
  parameter int   BOX_STEP   = 2
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst_n,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  input  logic        key_n,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [4:0]  out_r,
  output logic [5:0]  out_g,
  output logic [4:0]  out_b,
  output logic [2:0]  mode
);

  localparam logic [10:0] XLIM = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YLIM = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP = 11'(BOX_STEP);
  localparam logic [11:0] BSZ  = 12'(BOX_SIZE);

  logic       press;
  logic       vs_q;
  logic       fs;
  logic [2:0] pend;
  logic [7:0] frame_cnt;
  axis_t      bx_q;
  axis_t      by_q;
  s1_t        s1_d;
  s1_t        s1_q;
  logic [15:0] col;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk  (rgb_clk),
    .rst_n(rgb_rst_n),
    .key_n(key_n),
    .press(press)
  );

  assign fs = (in_vs == VS_POL) && (vs_q != VS_POL);

  // frame-start edge detect and per-frame state
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      vs_q      <= VS_POL;
      mode      <= MODE_BARS;
      frame_cnt <= '0;
      bx_q      <= '0;
      by_q      <= '0;
    end else begin
      vs_q <= in_vs;
      if (fs) begin
        mode      <= pend;
        frame_cnt <= frame_cnt + 8'd1;
        bx_q      <= axis_next(bx_q, XLIM, STEP);
        by_q      <= axis_next(by_q, YLIM, STEP);
      end
    end
  end

  // queued mode; presses land here first
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n)  pend <= MODE_BARS;
    else if (press)
      pend <= (pend == MODE_LAST) ? MODE_BARS
                                  : pend + 3'd1;
  end

  // stage-1 predicates for every pattern
  always_comb begin
    s1_d      = '0;
    s1_d.hs   = in_hs;
    s1_d.vs   = in_vs;
    s1_d.de   = in_de;
    s1_d.ramp = in_x[8:3];
    s1_d.bar  = bar_idx(in_x);
    s1_d.grid = (in_x[3:0] == 4'd0)
             || (in_y[3:0] == 4'd0)
             || (in_x == 11'(H_ACTIVE - 1))
             || (in_y == 11'(V_ACTIVE - 1));
    s1_d.box  = ({1'b0, in_x} >= {1'b0, bx_q.pos})
             && ({1'b0, in_x} <  {1'b0, bx_q.pos} + BSZ)
             && ({1'b0, in_y} >= {1'b0, by_q.pos})
             && ({1'b0, in_y} <  {1'b0, by_q.pos} + BSZ);
    s1_d.chk  = in_x[4] ^ in_y[4] ^ frame_cnt[5];
  end

  // stage-1 register
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) s1_q <= '0;
    else            s1_q <= s1_d;
  end

  // colour select by displayed mode
  always_comb begin
    col = C_BLACK;
    unique case (1'b1)
      (mode == MODE_BARS):  col = BAR_LUT[s1_q.bar];
      (mode == MODE_GRID):  col = s1_q.grid ? C_WHITE : C_BLACK;
      (mode == MODE_RAMP):  col = {s1_q.ramp[5:1],
                                   s1_q.ramp,
                                   s1_q.ramp[5:1]};
      (mode == MODE_BOX):   col = s1_q.box ? C_RED : C_BLUE;
      (mode == MODE_CHECK): col = s1_q.chk ? C_WHITE : C_BLACK;
      default:              col = C_BLACK;
    endcase
  end

  // stage-2 register; blank outside de
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
      {out_r, out_g, out_b} <= '0;
    end else begin
      out_hs <= s1_q.hs;
      out_vs <= s1_q.vs;
      out_de <= s1_q.de;
      {out_r, out_g, out_b} <= s1_q.de ? col : 16'h0000;
    end
  end

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb_rgb_pattern_gen: scoreboard bench for
// the RGB565 pattern source.
module tb_rgb_pattern_gen;

  localparam int H   = 480;
  localparam int V   = 272;
  localparam int BS  = 32;
  localparam int BST = 2;

  logic        rgb_clk   = 1'b0;
  logic        rgb_rst_n = 1'b0;
  logic        in_hs     = 1'b1;
  logic        in_vs     = 1'b1;
  logic        in_de     = 1'b0;
  logic [10:0] in_x      = '0;
  logic [10:0] in_y      = '0;
  logic        key_n     = 1'b1;
  logic        out_hs;
  logic        out_vs;
  logic        out_de;
  logic [4:0]  out_r;
  logic [5:0]  out_g;
  logic [4:0]  out_b;
  logic [2:0]  mode;

  rgb_pattern_gen #(
    .DEB_CYCLES(16)
  ) dut (
    .rgb_clk  (rgb_clk),
    .rgb_rst_n(rgb_rst_n),
    .in_hs    (in_hs),
    .in_vs    (in_vs),
    .in_de    (in_de),
    .in_x     (in_x),
    .in_y     (in_y),
    .key_n    (key_n),
    .out_hs   (out_hs),
    .out_vs   (out_vs),
    .out_de   (out_de),
    .out_r    (out_r),
    .out_g    (out_g),
    .out_b    (out_b),
    .mode     (mode)
  );

  always #5 rgb_clk = ~rgb_clk;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    int          x;
    int          y;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  int m_mode, m_pend, m_fc, m_prev;
  int bx, by, bxl, byl;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bar_col(int k);
    case (k)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] colour(int x, int y);
    int r, g, inb;
    case (m_mode)
      0: return bar_col(x / 60);
      1: return ((x % 16 == 0) || (y % 16 == 0) ||
                 (x == H - 1) || (y == V - 1))
                ? 16'hFFFF : 16'h0000;
      2: begin
        r = (x >> 4) & 31;
        g = (x >> 3) & 63;
        return 16'((r << 11) | (g << 5) | r);
      end
      3: begin
        inb = (x >= bx) && (x < bx + BS) &&
              (y >= by) && (y < by + BS);
        return inb ? 16'hF800 : 16'h001F;
      end
      4: return (((x >> 4) ^ (y >> 4) ^ (m_fc >> 5)) & 1)
                ? 16'hFFFF : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic axis(inout int p, inout int l,
                      input int act);
    if (l == 0) begin
      if (p >= act - BS - BST) begin
        p = act - BS;
        l = 1;
      end else p = p + BST;
    end else begin
      if (p <= BST) begin
        p = 0;
        l = 0;
      end else p = p - BST;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_fc = 0;
    bx = 0; by = 0; bxl = 0; byl = 0;
    m_prev = 1;
  endtask

  task automatic step(input int hs, input int vs,
                      input int de, input int x,
                      input int y);
    exp_t e;
    @(negedge rgb_clk);
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      chk("out_hs", out_hs, e.hs);
      chk("out_vs", out_vs, e.vs);
      chk("out_de", out_de, e.de);
      chk($sformatf("rgb(%0d,%0d)", e.x, e.y),
          {out_r, out_g, out_b}, e.rgb);
    end
    in_hs = hs[0];
    in_vs = vs[0];
    in_de = de[0];
    in_x  = 11'(x);
    in_y  = 11'(y);
    if (vs == 0 && m_prev == 1) begin
      m_mode = m_pend;
      m_fc   = (m_fc + 1) % 256;
      axis(bx, bxl, H);
      axis(by, byl, V);
    end
    m_prev = vs;
    e.hs  = hs[0];
    e.vs  = vs[0];
    e.de  = de[0];
    e.x   = x;
    e.y   = y;
    e.rgb = de != 0 ? colour(x, y) : 16'h0000;
    sbq.push_back(e);
  endtask

  task automatic blank(input int n);
    repeat (n) step(1, 1, 0, 0, 0);
  endtask

  task automatic px(input int x, input int y);
    step(1, 1, 1, x, y);
  endtask

  task automatic fstart();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
  endtask

  task automatic press(input int n, input int ok);
    key_n = 1'b0;
    blank(n);
    key_n = 1'b1;
    blank(30);
    if (ok != 0) m_pend = (m_pend + 1) % 5;
  endtask

  task automatic box_probe();
    int x, y;
    int dxs[5] = '{-1, 0, 1, 31, 32};
    int dys[4] = '{-1, 0, 31, 32};
    foreach (dxs[i])
      foreach (dys[j]) begin
        x = bx + dxs[i];
        y = by + dys[j];
        if (x >= 0 && x < H && y >= 0 && y < V)
          px(x, y);
      end
    blank(2);
  endtask

  initial begin
    int found;
    model_reset();
    repeat (3) @(negedge rgb_clk);
    chk("rst_hs", out_hs, 0);
    chk("rst_vs", out_vs, 0);
    chk("rst_de", out_de, 0);
    chk("rst_rgb", {out_r, out_g, out_b}, 0);
    chk("rst_mode", mode, 0);
    @(negedge rgb_clk);
    rgb_rst_n = 1'b1;

    blank(3);
    fstart();
    px(0, 100);
    px(59, 100);
    px(60, 100);
    px(420, 100);
    for (int x = 0; x < H; x += 13) px(x, 100);
    px(479, 100);
    blank(2);
    chk("mode_bars", mode, 0);

    press(10, 0);
    chk("mode_short", mode, 0);
    fstart();
    chk("mode_short_fs", mode, 0);
    press(40, 1);
    chk("mode_pending", mode, 0);
    fstart();
    chk("mode_grid", mode, 1);
    px(0, 5);   px(5, 5);   px(16, 7);
    px(7, 32);  px(479, 3); px(478, 3);
    px(3, 271); px(3, 270); px(17, 17);
    blank(2);

    press(40, 1);
    fstart();
    chk("mode_ramp", mode, 2);
    for (int x = 0; x < H; x += 11) px(x, 7);
    blank(2);

    press(40, 1);
    fstart();
    chk("mode_box", mode, 3);
    box_probe();
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (bx == 446 && bxl == 0) found = 1;
      else fstart();
    end
    chk("box_seek", found, 1);
    box_probe();
    fstart();
    box_probe();
    fstart();
    box_probe();

    press(40, 1);
    fstart();
    chk("mode_check", mode, 4);
    for (int f = 0; f < 70; f++) begin
      px(0, 0);
      px(32, 0);
      px(0, 32);
      px(16, 16);
      fstart();
    end
    blank(2);

    press(40, 1);
    fstart();
    chk("mode_wrap", mode, 0);
    press(40, 1);
    press(40, 1);
    chk("mode_two_pend", mode, 0);
    fstart();
    chk("mode_two", mode, 2);

    px(10, 10);
    px(11, 10);
    @(posedge rgb_clk);
    #2;
    rgb_rst_n = 1'b0;
    #1;
    chk("arst_hs", out_hs, 0);
    chk("arst_vs", out_vs, 0);
    chk("arst_de", out_de, 0);
    chk("arst_rgb", {out_r, out_g, out_b}, 0);
    chk("arst_mode", mode, 0);
    sbq.delete();
    model_reset();
    repeat (2) @(negedge rgb_clk);
    rgb_rst_n = 1'b1;
    blank(2);
    px(0, 50);
    px(100, 50);
    px(300, 50);
    blank(3);
    chk("post_rst_mode", mode, 0);
    fstart();
    chk("post_rst_fs", mode, 0);
    px(200, 60);
    blank(3);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
